// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access over a req/ack bus, then the write-back register.
// Latency: non-access ops reach WB one edge after capture; each bus wait cycle adds one.
// Backpressure: o_MEM_stall holds upstream while a bus access waits for ack or timeout.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_MEM_dmemWe,
    input  logic        i_MEM_regWe,
    input  logic        i_MEM_sWD,
    input  logic [4:0]  i_MEM_WRA,
    input  logic [31:0] i_MEM_aluOut,
    input  logic [31:0] i_MEM_rd2,
    output logic        o_MEM_stall,
    output logic        o_MEM_req,
    output logic        o_MEM_we,
    output logic [31:0] o_MEM_addr,
    output logic [31:0] o_MEM_wdata,
    input  logic        i_MEM_ack,
    input  logic [31:0] i_MEM_rdata,
    output logic        o_MEM_regWe,
    output logic [4:0]  o_MEM_WRA,
    output logic [31:0] o_MEM_WD,
    output logic        o_MEM_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        dmem_we;
        logic        reg_we;
        logic        s_wd;
        logic [4:0]  wra;
        logic [31:0] alu_out;
        logic [31:0] rd2;
    } stage_t;

    stage_t      r;
    state_t      state;
    logic [31:0] cnt;

    logic busy;
    logic access;
    logic mis;
    logic is_load;
    logic tmo;
    logic stall;
    logic complete;
    logic in_go;

    assign busy    = (state == BUSY);
    assign is_load = r.s_wd & ~r.dmem_we;
    assign access  = r.dmem_we | is_load;
    assign mis     = access & (r.alu_out[1:0] != 2'b00);
    // Timeout only meaningful while an access is outstanding; TIMEOUT=0 disables it.
    assign tmo     = busy & (TIMEOUT != 0) & (cnt == 32'(TIMEOUT - 1)) & ~i_MEM_ack;
    assign stall   = busy & ~i_MEM_ack & ~tmo;
    // The op entering R starts a bus access only if it is an aligned load/store.
    assign in_go   = (i_MEM_dmemWe | i_MEM_sWD) & (i_MEM_aluOut[1:0] == 2'b00);
    assign complete = ~access | mis | (busy & i_MEM_ack) | tmo;

    assign o_MEM_stall = stall;
    assign o_MEM_req   = busy;
    assign o_MEM_we    = r.dmem_we;
    assign o_MEM_addr  = r.alu_out;
    assign o_MEM_wdata = r.rd2;

    // Stage register: captures the EXE bundle whenever the stage is not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (!stall) begin
            r.dmem_we <= i_MEM_dmemWe;
            r.reg_we  <= i_MEM_regWe;
            r.s_wd    <= i_MEM_sWD;
            r.wra     <= i_MEM_WRA;
            r.alu_out <= i_MEM_aluOut;
            r.rd2     <= i_MEM_rd2;
        end
    end

    // Bus FSM and wait counter: leave BUSY on ack/timeout, re-enter on the next aligned access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!stall) begin
            state <= in_go ? BUSY : IDLE;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + 32'd1;
        end
    end

    // Write-back register: loads every edge; stall cycles become bubbles with regWe=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_MEM_regWe <= 1'b0;
            o_MEM_WRA   <= '0;
            o_MEM_WD    <= '0;
            o_MEM_err   <= 1'b0;
        end else begin
            o_MEM_regWe <= complete & r.reg_we & ~mis & ~tmo;
            o_MEM_WRA   <= r.wra;
            o_MEM_WD    <= is_load ? i_MEM_rdata : r.alu_out;
            o_MEM_err   <= complete & (mis | tmo);
        end
    end

endmodule
